// File: rtl/axi_filter_wr_channel.sv
// AXI4 write-channel address filter: blocked AWs are answered locally with SLVERR.
// Optional error counter (o_err_cnt / i_err_cnt_clr) enabled by AXI_FILTER_WR_ERR_CNT_EN.
module axi_filter_wr_channel #(
    parameter int AXI_ADDR_WIDTH      = 32,
    parameter int AXI_DATA_WIDTH      = 64,
    parameter int AXI_STRB_WIDTH      = AXI_DATA_WIDTH / 8,
    parameter int AXI_ID_WIDTH        = 7,
    parameter int AXI_USER_WIDTH      = 4,
    parameter int NBR_RANGE           = 1,
    parameter int NBR_OUTSTANDING_REQ = 4,
    parameter int AXI_LOOK_BITS       = 4
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst_n,
    input  logic                                     i_scan_ckgt_enable,
    input  logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0] START_ADDR,
    input  logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0] STOP_ADDR,
    // slave-side AW
    input  logic                      axi_in_aw_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_in_aw_addr_i,
    input  logic [2:0]                axi_in_aw_prot_i,
    input  logic [3:0]                axi_in_aw_region_i,
    input  logic [7:0]                axi_in_aw_len_i,
    input  logic [2:0]                axi_in_aw_size_i,
    input  logic [1:0]                axi_in_aw_burst_i,
    input  logic                      axi_in_aw_lock_i,
    input  logic [3:0]                axi_in_aw_cache_i,
    input  logic [3:0]                axi_in_aw_qos_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_in_aw_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_in_aw_user_i,
    output logic                      axi_in_aw_ready_o,
    // slave-side W
    input  logic                      axi_in_w_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0] axi_in_w_data_i,
    input  logic [AXI_STRB_WIDTH-1:0] axi_in_w_strb_i,
    input  logic                      axi_in_w_last_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_in_w_user_i,
    output logic                      axi_in_w_ready_o,
    // slave-side B
    output logic                      axi_in_b_valid_o,
    output logic [1:0]                axi_in_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_in_b_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_in_b_user_o,
    input  logic                      axi_in_b_ready_i,
    // master-side AW
    output logic                      axi_out_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] axi_out_aw_addr_o,
    output logic [2:0]                axi_out_aw_prot_o,
    output logic [3:0]                axi_out_aw_region_o,
    output logic [7:0]                axi_out_aw_len_o,
    output logic [2:0]                axi_out_aw_size_o,
    output logic [1:0]                axi_out_aw_burst_o,
    output logic                      axi_out_aw_lock_o,
    output logic [3:0]                axi_out_aw_cache_o,
    output logic [3:0]                axi_out_aw_qos_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_out_aw_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_out_aw_user_o,
    input  logic                      axi_out_aw_ready_i,
    // master-side W
    output logic                      axi_out_w_valid_o,
    output logic [AXI_DATA_WIDTH-1:0] axi_out_w_data_o,
    output logic [AXI_STRB_WIDTH-1:0] axi_out_w_strb_o,
    output logic                      axi_out_w_last_o,
    output logic [AXI_USER_WIDTH-1:0] axi_out_w_user_o,
    input  logic                      axi_out_w_ready_i,
    // master-side B
    input  logic                      axi_out_b_valid_i,
    input  logic [1:0]                axi_out_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_out_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_out_b_user_i,
    output logic                      axi_out_b_ready_o
`ifdef AXI_FILTER_WR_ERR_CNT_EN
    ,
    input  logic                      i_err_cnt_clr,
    output logic [15:0]               o_err_cnt
`endif
);

    localparam int DEPTH = NBR_OUTSTANDING_REQ;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int NID   = 2 ** AXI_LOOK_BITS;

    typedef struct packed {
        logic                      err;
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_USER_WIDTH-1:0] user;
    } rs_entry_t;

    typedef enum logic {
        B_IDLE,
        B_ERR
    } b_state_e;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // scan enable only matters for clock gating, which this FIFO does not use
    logic unused_scan;
    assign unused_scan = i_scan_ckgt_enable;

    // route FIFO: one is_error flag per accepted AW, consumed by W routing
    logic           rt_mem_q [DEPTH];
    logic [PW-1:0]  rt_wr_q, rt_rd_q;
    logic [CW-1:0]  rt_cnt_q, rt_cnt_d;
    logic           rt_full, rt_empty, rt_head, rt_pop;

    // resp FIFO: is_error/id/user per accepted AW, consumed by B
    rs_entry_t      rs_mem_q [DEPTH];
    logic [PW-1:0]  rs_wr_q, rs_rd_q;
    logic [CW-1:0]  rs_cnt_q, rs_cnt_d;
    logic           rs_full, rs_empty, rs_pop;
    rs_entry_t      rs_head;

    logic [NID-1:0] inflight_q, inflight_d;
    logic [CW-1:0]  err_done_q, err_done_d;
    b_state_e       b_state_q, b_state_d;

    logic aw_blocked, aw_can, fifo_push, err_inc, err_dec;
    logic [AXI_LOOK_BITS-1:0] clr_idx;

    assign rt_full  = (rt_cnt_q == CW'(DEPTH));
    assign rt_empty = (rt_cnt_q == '0);
    assign rt_head  = rt_mem_q[rt_rd_q];
    assign rs_full  = (rs_cnt_q == CW'(DEPTH));
    assign rs_empty = (rs_cnt_q == '0);
    assign rs_head  = rs_mem_q[rs_rd_q];

    // address match against every inclusive blocked range
    always_comb begin
        aw_blocked = 1'b0;
        for (int i = 0; i < NBR_RANGE; i++) begin
            if (axi_in_aw_addr_i >= START_ADDR[i] && axi_in_aw_addr_i <= STOP_ADDR[i]) begin
                aw_blocked = 1'b1;
            end
        end
    end

    assign aw_can = axi_in_aw_valid_i & ~rt_full & ~rs_full
                  & ~inflight_q[axi_in_aw_id_i[AXI_LOOK_BITS-1:0]];

    assign axi_out_aw_valid_o = aw_can & ~aw_blocked;
    assign axi_in_aw_ready_o  = aw_can & (aw_blocked | axi_out_aw_ready_i);
    assign fifo_push          = axi_in_aw_valid_i & axi_in_aw_ready_o;

    assign axi_out_aw_addr_o   = axi_in_aw_addr_i;
    assign axi_out_aw_prot_o   = axi_in_aw_prot_i;
    assign axi_out_aw_region_o = axi_in_aw_region_i;
    assign axi_out_aw_len_o    = axi_in_aw_len_i;
    assign axi_out_aw_size_o   = axi_in_aw_size_i;
    assign axi_out_aw_burst_o  = axi_in_aw_burst_i;
    assign axi_out_aw_lock_o   = axi_in_aw_lock_i;
    assign axi_out_aw_cache_o  = axi_in_aw_cache_i;
    assign axi_out_aw_qos_o    = axi_in_aw_qos_i;
    assign axi_out_aw_id_o     = axi_in_aw_id_i;
    assign axi_out_aw_user_o   = axi_in_aw_user_i;

    assign axi_out_w_data_o = axi_in_w_data_i;
    assign axi_out_w_strb_o = axi_in_w_strb_i;
    assign axi_out_w_last_o = axi_in_w_last_i;
    assign axi_out_w_user_o = axi_in_w_user_i;

    // W routing: forward or sink according to the route FIFO head
    always_comb begin
        axi_out_w_valid_o = 1'b0;
        axi_in_w_ready_o  = 1'b0;
        rt_pop            = 1'b0;
        err_inc           = 1'b0;
        if (!rt_empty) begin
            if (rt_head) begin
                axi_in_w_ready_o = 1'b1;
                rt_pop  = axi_in_w_valid_i & axi_in_w_last_i;
                err_inc = rt_pop;
            end else begin
                axi_out_w_valid_o = axi_in_w_valid_i;
                axi_in_w_ready_o  = axi_out_w_ready_i;
                rt_pop = axi_in_w_valid_i & axi_out_w_ready_i & axi_in_w_last_i;
            end
        end
    end

    // B path: pass-through for forwarded writes, local SLVERR for sunk ones
    always_comb begin
        axi_in_b_valid_o  = 1'b0;
        axi_out_b_ready_o = 1'b0;
        axi_in_b_resp_o   = axi_out_b_resp_i;
        axi_in_b_id_o     = axi_out_b_id_i;
        axi_in_b_user_o   = axi_out_b_user_i;
        clr_idx           = axi_out_b_id_i[AXI_LOOK_BITS-1:0];
        rs_pop            = 1'b0;
        err_dec           = 1'b0;
        b_state_d         = b_state_q;
        unique case (b_state_q)
            B_IDLE: begin
                if (!rs_empty) begin
                    if (!rs_head.err) begin
                        axi_in_b_valid_o  = axi_out_b_valid_i;
                        axi_out_b_ready_o = axi_in_b_ready_i;
                        rs_pop = axi_out_b_valid_i & axi_in_b_ready_i;
                    end else if (err_done_q != '0) begin
                        b_state_d = B_ERR;
                    end
                end
            end
            B_ERR: begin
                axi_in_b_valid_o = 1'b1;
                axi_in_b_resp_o  = 2'b10;
                axi_in_b_id_o    = rs_head.id;
                axi_in_b_user_o  = rs_head.user;
                clr_idx          = rs_head.id[AXI_LOOK_BITS-1:0];
                if (axi_in_b_ready_i) begin
                    rs_pop    = 1'b1;
                    err_dec   = 1'b1;
                    b_state_d = B_IDLE;
                end
            end
        endcase
    end

    // next-state for counters and in-flight table; a new AW wins over a clear
    always_comb begin
        rt_cnt_d = rt_cnt_q;
        rs_cnt_d = rs_cnt_q;
        err_done_d = err_done_q;
        inflight_d = inflight_q;
        unique case ({fifo_push, rt_pop})
            2'b10:   rt_cnt_d = rt_cnt_q + 1'b1;
            2'b01:   rt_cnt_d = rt_cnt_q - 1'b1;
            default: rt_cnt_d = rt_cnt_q;
        endcase
        unique case ({fifo_push, rs_pop})
            2'b10:   rs_cnt_d = rs_cnt_q + 1'b1;
            2'b01:   rs_cnt_d = rs_cnt_q - 1'b1;
            default: rs_cnt_d = rs_cnt_q;
        endcase
        unique case ({err_inc, err_dec})
            2'b10:   err_done_d = err_done_q + 1'b1;
            2'b01:   err_done_d = err_done_q - 1'b1;
            default: err_done_d = err_done_q;
        endcase
        if (rs_pop) begin
            inflight_d[clr_idx] = 1'b0;
        end
        if (fifo_push) begin
            inflight_d[axi_in_aw_id_i[AXI_LOOK_BITS-1:0]] = 1'b1;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rt_wr_q <= '0;
            rt_rd_q <= '0;
            rs_wr_q <= '0;
            rs_rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rt_mem_q[i] <= 1'b0;
                rs_mem_q[i] <= '0;
            end
        end else begin
            if (fifo_push) begin
                rt_mem_q[rt_wr_q] <= aw_blocked;
                rs_mem_q[rs_wr_q] <= '{err: aw_blocked, id: axi_in_aw_id_i, user: axi_in_aw_user_i};
                rt_wr_q <= ptr_inc(rt_wr_q);
                rs_wr_q <= ptr_inc(rs_wr_q);
            end
            if (rt_pop) begin
                rt_rd_q <= ptr_inc(rt_rd_q);
            end
            if (rs_pop) begin
                rs_rd_q <= ptr_inc(rs_rd_q);
            end
        end
    end

    // counters, in-flight table and B state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rt_cnt_q   <= '0;
            rs_cnt_q   <= '0;
            err_done_q <= '0;
            inflight_q <= '0;
            b_state_q  <= B_IDLE;
        end else begin
            rt_cnt_q   <= rt_cnt_d;
            rs_cnt_q   <= rs_cnt_d;
            err_done_q <= err_done_d;
            inflight_q <= inflight_d;
            b_state_q  <= b_state_d;
        end
    end

`ifdef AXI_FILTER_WR_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // saturating count of blocked AW acceptances; clear wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt_q <= '0;
        end else if (i_err_cnt_clr) begin
            err_cnt_q <= '0;
        end else if (fifo_push && aw_blocked && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi_filter_wr_channel.sv
// Self-checking bench for axi_filter_wr_channel.
// Scoreboard of expected B responses and a downstream slave queue.
module tb_axi_filter_wr_channel;

  localparam logic [31:0] R_LO = 32'h0000_8000;
  localparam logic [31:0] R_HI = 32'h0000_8FFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [0:0][31:0] start_addr, stop_addr;
  logic scan;

  logic        in_aw_valid, in_aw_ready;
  logic [31:0] in_aw_addr;
  logic [2:0]  in_aw_prot, in_aw_size;
  logic [3:0]  in_aw_region, in_aw_cache, in_aw_qos, in_aw_user;
  logic [7:0]  in_aw_len;
  logic [1:0]  in_aw_burst;
  logic        in_aw_lock;
  logic [6:0]  in_aw_id;

  logic        in_w_valid, in_w_ready, in_w_last;
  logic [63:0] in_w_data;
  logic [7:0]  in_w_strb;
  logic [3:0]  in_w_user;

  logic        in_b_valid, in_b_ready;
  logic [1:0]  in_b_resp;
  logic [6:0]  in_b_id;
  logic [3:0]  in_b_user;

  logic        out_aw_valid, out_aw_ready;
  logic [31:0] out_aw_addr;
  logic [2:0]  out_aw_prot, out_aw_size;
  logic [3:0]  out_aw_region, out_aw_cache, out_aw_qos, out_aw_user;
  logic [7:0]  out_aw_len;
  logic [1:0]  out_aw_burst;
  logic        out_aw_lock;
  logic [6:0]  out_aw_id;

  logic        out_w_valid, out_w_ready, out_w_last;
  logic [63:0] out_w_data;
  logic [7:0]  out_w_strb;
  logic [3:0]  out_w_user;

  logic        out_b_valid, out_b_ready;
  logic [1:0]  out_b_resp;
  logic [6:0]  out_b_id;
  logic [3:0]  out_b_user;

`ifdef AXI_FILTER_WR_ERR_CNT_EN
  logic        err_clr;
  logic [15:0] err_cnt;
`endif

  axi_filter_wr_channel dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scan_ckgt_enable(scan),
    .START_ADDR(start_addr), .STOP_ADDR(stop_addr),
    .axi_in_aw_valid_i(in_aw_valid), .axi_in_aw_addr_i(in_aw_addr),
    .axi_in_aw_prot_i(in_aw_prot), .axi_in_aw_region_i(in_aw_region),
    .axi_in_aw_len_i(in_aw_len), .axi_in_aw_size_i(in_aw_size),
    .axi_in_aw_burst_i(in_aw_burst), .axi_in_aw_lock_i(in_aw_lock),
    .axi_in_aw_cache_i(in_aw_cache), .axi_in_aw_qos_i(in_aw_qos),
    .axi_in_aw_id_i(in_aw_id), .axi_in_aw_user_i(in_aw_user),
    .axi_in_aw_ready_o(in_aw_ready),
    .axi_in_w_valid_i(in_w_valid), .axi_in_w_data_i(in_w_data),
    .axi_in_w_strb_i(in_w_strb), .axi_in_w_last_i(in_w_last),
    .axi_in_w_user_i(in_w_user), .axi_in_w_ready_o(in_w_ready),
    .axi_in_b_valid_o(in_b_valid), .axi_in_b_resp_o(in_b_resp),
    .axi_in_b_id_o(in_b_id), .axi_in_b_user_o(in_b_user),
    .axi_in_b_ready_i(in_b_ready),
    .axi_out_aw_valid_o(out_aw_valid), .axi_out_aw_addr_o(out_aw_addr),
    .axi_out_aw_prot_o(out_aw_prot), .axi_out_aw_region_o(out_aw_region),
    .axi_out_aw_len_o(out_aw_len), .axi_out_aw_size_o(out_aw_size),
    .axi_out_aw_burst_o(out_aw_burst), .axi_out_aw_lock_o(out_aw_lock),
    .axi_out_aw_cache_o(out_aw_cache), .axi_out_aw_qos_o(out_aw_qos),
    .axi_out_aw_id_o(out_aw_id), .axi_out_aw_user_o(out_aw_user),
    .axi_out_aw_ready_i(out_aw_ready),
    .axi_out_w_valid_o(out_w_valid), .axi_out_w_data_o(out_w_data),
    .axi_out_w_strb_o(out_w_strb), .axi_out_w_last_o(out_w_last),
    .axi_out_w_user_o(out_w_user), .axi_out_w_ready_i(out_w_ready),
    .axi_out_b_valid_i(out_b_valid), .axi_out_b_resp_i(out_b_resp),
    .axi_out_b_id_i(out_b_id), .axi_out_b_user_i(out_b_user),
    .axi_out_b_ready_o(out_b_ready)
`ifdef AXI_FILTER_WR_ERR_CNT_EN
    ,
    .i_err_cnt_clr(err_clr), .o_err_cnt(err_cnt)
`endif
  );

  typedef struct packed {
    logic [6:0] id;
    logic [1:0] resp;
    logic [3:0] user;
  } bexp_t;

  typedef struct packed {
    logic [6:0] id;
    logic [3:0] user;
  } ds_t;

  bexp_t exp_q[$];
  ds_t   ds_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit is_blocked(input logic [31:0] a);
    return (a >= R_LO) && (a <= R_HI);
  endfunction

  task automatic push_model(input logic [6:0] id, input logic [3:0] user,
                            input bit blk);
    bexp_t e;
    ds_t   d;
    e.id = id;
    e.resp = blk ? 2'b10 : 2'b00;
    e.user = user;
    exp_q.push_back(e);
    if (!blk) begin
      d.id = id;
      d.user = user;
      ds_q.push_back(d);
    end
  endtask

  task automatic do_aw(input logic [31:0] addr, input logic [6:0] id,
                       input logic [3:0] user, input logic [7:0] len,
                       output bit blk);
    bit done;
    logic [24:0] attr;
    done = 0;
    blk = is_blocked(addr);
    @(negedge clk);
    in_aw_valid = 1'b1;
    in_aw_addr = addr;
    in_aw_id = id;
    in_aw_user = user;
    in_aw_len = len;
    {in_aw_prot, in_aw_region, in_aw_size, in_aw_burst, in_aw_lock,
     in_aw_cache, in_aw_qos} = 21'($urandom);
    for (int c = 0; c < 50 && !done; c++) begin
      #1;
      if (in_aw_ready) begin
        chk("aw_out_valid", 64'(out_aw_valid), 64'(!blk));
        if (!blk) begin
          chk("aw_out_addr", 64'(out_aw_addr), 64'(addr));
          chk("aw_out_id", 64'(out_aw_id), 64'(id));
          attr = {out_aw_len, out_aw_user, out_aw_prot, out_aw_region,
                  out_aw_size, out_aw_burst, out_aw_lock};
          chk("aw_out_attr", 64'(attr),
              64'({len, user, in_aw_prot, in_aw_region, in_aw_size,
                   in_aw_burst, in_aw_lock}));
          chk("aw_out_cq", 64'({out_aw_cache, out_aw_qos}),
              64'({in_aw_cache, in_aw_qos}));
        end
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (done) push_model(id, user, blk);
    else chk("aw_timeout", 64'(0), 64'(1));
    #1;
    in_aw_valid = 1'b0;
  endtask

  task automatic do_w(input logic [7:0] len, input bit blk);
    bit done;
    logic [63:0] data;
    for (int b = 0; b <= int'(len); b++) begin
      done = 0;
      data = {$urandom, $urandom};
      @(negedge clk);
      in_w_valid = 1'b1;
      in_w_data = data;
      in_w_strb = 8'($urandom);
      in_w_user = 4'($urandom);
      in_w_last = (b == int'(len));
      for (int c = 0; c < 50 && !done; c++) begin
        #1;
        if (in_w_ready) begin
          chk("w_out_valid", 64'(out_w_valid), 64'(!blk));
          if (!blk) begin
            chk("w_out_data", out_w_data, data);
            chk("w_out_misc", 64'({out_w_last, out_w_strb, out_w_user}),
                64'({in_w_last, in_w_strb, in_w_user}));
          end
          @(posedge clk);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
      if (!done) chk("w_timeout", 64'(0), 64'(1));
      #1;
      in_w_valid = 1'b0;
      in_w_last = 1'b0;
    end
  endtask

  task automatic write(input logic [31:0] addr, input logic [6:0] id,
                       input logic [3:0] user, input logic [7:0] len);
    bit blk;
    do_aw(addr, id, user, len, blk);
    do_w(len, blk);
  endtask

  task automatic drain_b(input int n);
    int got;
    bit hs_in, hs_ds;
    got = 0;
    for (int c = 0; c < 300 && got < n; c++) begin
      @(negedge clk);
      in_b_ready = 1'b1;
      if (ds_q.size() > 0) begin
        out_b_valid = 1'b1;
        out_b_id = ds_q[0].id;
        out_b_user = ds_q[0].user;
        out_b_resp = 2'b00;
      end else begin
        out_b_valid = 1'b0;
      end
      #1;
      hs_in = in_b_valid;
      hs_ds = out_b_valid && out_b_ready;
      if (hs_in) begin
        if (exp_q.size() == 0) begin
          chk("b_unexpected", 64'(1), 64'(0));
        end else begin
          chk("b_id", 64'(in_b_id), 64'(exp_q[0].id));
          chk("b_resp", 64'(in_b_resp), 64'(exp_q[0].resp));
          chk("b_user", 64'(in_b_user), 64'(exp_q[0].user));
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (hs_ds) void'(ds_q.pop_front());
      @(posedge clk);
    end
    chk("b_drain_count", 64'(got), 64'(n));
    #1;
    out_b_valid = 1'b0;
    in_b_ready = 1'b0;
  endtask

  function automatic logic [5:0] hs_vec();
    return {in_aw_ready, out_aw_valid, in_w_ready, out_w_valid,
            in_b_valid, out_b_ready};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    logic [6:0] base, id;
    logic [31:0] addr;

    rst_n = 1'b0;
    scan = 1'b0;
    start_addr[0] = R_LO;
    stop_addr[0] = R_HI;
    in_aw_valid = 0; in_aw_addr = 0; in_aw_prot = 0; in_aw_region = 0;
    in_aw_len = 0; in_aw_size = 0; in_aw_burst = 0; in_aw_lock = 0;
    in_aw_cache = 0; in_aw_qos = 0; in_aw_id = 0; in_aw_user = 0;
    in_w_valid = 0; in_w_data = 0; in_w_strb = 0; in_w_last = 0;
    in_w_user = 0; in_b_ready = 0;
    out_aw_ready = 1; out_w_ready = 1;
    out_b_valid = 0; out_b_resp = 0; out_b_id = 0; out_b_user = 0;
`ifdef AXI_FILTER_WR_ERR_CNT_EN
    err_clr = 0;
`endif

    #1;
    chk("reset_hs", 64'(hs_vec()), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_hs", 64'(hs_vec()), 64'(0));

    // allowed single write, then B with backpressure
    write(32'h1000, 7'd3, 4'd1, 8'd0);
    @(negedge clk);
    out_b_valid = 1'b1; out_b_id = 7'd3; out_b_user = 4'd1;
    out_b_resp = 2'b00; in_b_ready = 1'b0;
    #1;
    chk("ok_b_valid", 64'(in_b_valid), 64'(1));
    chk("ok_b_id", 64'(in_b_id), 64'(exp_q[0].id));
    chk("ok_b_resp", 64'(in_b_resp), 64'(exp_q[0].resp));
    chk("ok_out_b_ready_lo", 64'(out_b_ready), 64'(0));
    @(negedge clk);
    in_b_ready = 1'b1;
    #1;
    chk("ok_out_b_ready_hi", 64'(out_b_ready), 64'(1));
    @(posedge clk);
    void'(exp_q.pop_front());
    void'(ds_q.pop_front());
    #1;
    out_b_valid = 1'b0;
    in_b_ready = 1'b0;

    // blocked write: 4 beats sunk, SLVERR not before one cycle after last
    write(32'h8010, 7'd5, 4'd2, 8'd3);
    chk("err_b_not_early", 64'(in_b_valid), 64'(0));
    drain_b(1);

    // ordering: blocked then allowed
    write(32'h8100, 7'd1, 4'd7, 8'd1);
    write(32'h2000, 7'd2, 4'd9, 8'd0);
    drain_b(2);

    // range boundaries
    write(32'h7FFF, 7'd8, 4'd1, 8'd0);
    write(32'h8000, 7'd9, 4'd2, 8'd1);
    write(32'h8FFF, 7'd10, 4'd3, 8'd0);
    write(32'h9000, 7'd11, 4'd4, 8'd2);
    drain_b(4);

    // ID reuse stall: 0x13 then 0x03
    write(32'h3000, 7'h13, 4'd0, 8'd0);
    @(negedge clk);
    in_aw_valid = 1'b1; in_aw_addr = 32'h3100; in_aw_id = 7'h03;
    in_aw_len = 0; in_aw_user = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("idreuse_stall", 64'(in_aw_ready), 64'(0));
      @(negedge clk);
    end
    out_b_valid = 1'b1; out_b_id = 7'h13; out_b_user = 0; out_b_resp = 0;
    in_b_ready = 1'b1;
    #1;
    chk("idreuse_b_valid", 64'(in_b_valid), 64'(1));
    chk("idreuse_b_id", 64'(in_b_id), 64'(exp_q[0].id));
    chk("idreuse_stall_hs", 64'(in_aw_ready), 64'(0));
    @(posedge clk);
    void'(exp_q.pop_front());
    void'(ds_q.pop_front());
    #1;
    out_b_valid = 1'b0;
    in_b_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("idreuse_accept", 64'(in_aw_ready), 64'(1));
    @(posedge clk);
    push_model(7'h03, 4'd0, 1'b0);
    #1;
    in_aw_valid = 1'b0;
    do_w(8'd0, 1'b0);
    drain_b(1);

    // FIFO full: 4 outstanding, 5th stalls until one B
    for (int i = 0; i < 4; i++)
      write(32'h4000 + 32'(i) * 32'h100, 7'(i), 4'(i), 8'd0);
    @(negedge clk);
    in_aw_valid = 1'b1; in_aw_addr = 32'h5000; in_aw_id = 7'd4;
    in_aw_user = 4'd4; in_aw_len = 0;
    #1;
    chk("full_stall0", 64'(in_aw_ready), 64'(0));
    @(negedge clk);
    #1;
    chk("full_stall1", 64'(in_aw_ready), 64'(0));
    out_b_valid = 1'b1; out_b_id = 7'd0; out_b_user = 4'd0; out_b_resp = 0;
    in_b_ready = 1'b1;
    #1;
    chk("full_b_valid", 64'(in_b_valid), 64'(1));
    chk("full_b_id", 64'(in_b_id), 64'(exp_q[0].id));
    chk("full_stall2", 64'(in_aw_ready), 64'(0));
    @(posedge clk);
    void'(exp_q.pop_front());
    void'(ds_q.pop_front());
    #1;
    out_b_valid = 1'b0;
    in_b_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("full_accept", 64'(in_aw_ready), 64'(1));
    @(posedge clk);
    push_model(7'd4, 4'd4, 1'b0);
    #1;
    in_aw_valid = 1'b0;
    do_w(8'd0, 1'b0);
    drain_b(4);

`ifdef AXI_FILTER_WR_ERR_CNT_EN
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    write(32'h8000, 7'd1, 4'd0, 8'd0);
    write(32'h8400, 7'd2, 4'd0, 8'd0);
    write(32'h8FFF, 7'd3, 4'd0, 8'd0);
    #1;
    chk("err_cnt_3", 64'(err_cnt), 64'(3));
    drain_b(3);
    @(negedge clk);
    err_clr = 1'b1;
    in_aw_valid = 1'b1; in_aw_addr = 32'h8800; in_aw_id = 7'd5;
    in_aw_user = 0; in_aw_len = 0;
    #1;
    chk("err_clr_accept", 64'(in_aw_ready), 64'(1));
    @(posedge clk);
    push_model(7'd5, 4'd0, 1'b1);
    #1;
    in_aw_valid = 1'b0;
    err_clr = 1'b0;
    chk("err_cnt_clr", 64'(err_cnt), 64'(0));
    do_w(8'd0, 1'b1);
    drain_b(1);
`endif

    // randomized batches with distinct ID LSBs inside each batch
    for (int bt = 0; bt < 12; bt++) begin
      k = $urandom_range(1, 4);
      base = 7'($urandom);
      for (int i = 0; i < k; i++) begin
        id = {3'($urandom), 4'(32'(base[3:0]) + i)};
        if ($urandom_range(0, 1) == 1)
          addr = R_LO + 32'($urandom_range(0, 32'hFFF));
        else
          addr = $urandom;
        write(addr, id, 4'($urandom), 8'($urandom_range(0, 3)));
      end
      drain_b(k);
    end

    chk("model_empty", 64'(exp_q.size() + ds_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
